// File: rtl/axis_frame_packer.sv
// axis_frame_packer: packs a continuous, non-backpressured sample stream into
// AXI4-Stream frames made of a sequence-number header followed by FRAME_LEN
// payload words. Frames that lose samples are closed early with a terminator
// word (tlast=1, tuser=1) so that a downstream drop-on-bad FIFO discards them.
// A 4-entry register FIFO absorbs up to two pushes and one pop per cycle.
module axis_frame_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  sync_in,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  status_drop,
  output logic [SEQ_WIDTH-1:0]  frame_count
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DISCARD} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        pos, pos_nxt, pos_eff;
  logic [SEQ_WIDTH-1:0] seq, seq_nxt, fcnt_nxt;
  logic                 pend, pend_nxt, drop_nxt;
  logic                 term_now, start;
  logic                 push_term, push_hdr, push_smp, smp_last;

  logic [EW-1:0]        buf_mem [4];
  logic [1:0]           rd_ptr, wr_ptr;
  logic [2:0]           count, free, room;
  logic                 pop;
  logic [1:0]           n_push;
  logic [EW-1:0]        push_w0, push_w1;

  function automatic logic [PW-1:0] pos_inc(input logic [PW-1:0] p);
    return (p == POS_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [EW-1:0] word_pack(input logic [DATA_WIDTH-1:0] d,
                                              input logic l, input logic u);
    return {d, l, u};
  endfunction

  // Buffer head drives the stream; free space already accounts for this cycle's pop.
  assign pop           = (count != 3'd0) && m_axis_tready;
  assign free          = 3'd4 - count + {2'b00, pop};
  assign m_axis_tvalid = (count != 3'd0);
  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = buf_mem[rd_ptr];

  // Frame control: decides which words are pushed and the next state.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    pos_eff   = pos;
    seq_nxt   = seq;
    fcnt_nxt  = frame_count;
    pend_nxt  = pend;
    drop_nxt  = 1'b0;
    push_term = 1'b0;
    push_hdr  = 1'b0;
    push_smp  = 1'b0;
    smp_last  = 1'b0;
    start     = 1'b0;

    // A pending terminator goes out first and eats one of the two push slots.
    term_now = pend && (free != 3'd0);
    if (term_now) begin
      push_term = 1'b1;
      pend_nxt  = 1'b0;
    end
    room = ((free > 3'd2) ? 3'd2 : free) - {2'b00, term_now};

    if (din_valid) begin
      unique case (state)
        IDLE: begin
          if (sync_in && enable) begin
            start   = 1'b1;
            pos_eff = '0;
          end
        end
        RUN: begin
          if (sync_in && (pos != '0)) begin
            // Mid-frame resync: close the frame as bad and wait for a new sync.
            pos_nxt   = '0;
            state_nxt = IDLE;
            drop_nxt  = 1'b1;
            if (room != 3'd0) push_term = 1'b1;
            else              pend_nxt  = 1'b1;
          end else begin
            start = 1'b1;
          end
        end
        DISCARD: begin
          if (sync_in) pos_eff = '0;
          if ((pos_eff == '0) && enable && !pend && (room >= 3'd2)) start = 1'b1;
          else                                                        pos_nxt = pos_inc(pos_eff);
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (start) begin
      if (room < ((pos_eff == '0) ? 3'd2 : 3'd1)) begin
        // No room: the sample is lost; a started frame must be closed as bad.
        pos_nxt   = pos_inc(pos_eff);
        state_nxt = DISCARD;
        if (pos_eff != '0) begin
          pend_nxt = 1'b1;
          drop_nxt = 1'b1;
        end
      end else begin
        push_hdr  = (pos_eff == '0);
        if (push_hdr) seq_nxt = seq + 1'b1;
        push_smp  = 1'b1;
        smp_last  = (pos_eff == POS_LAST);
        pos_nxt   = pos_inc(pos_eff);
        state_nxt = RUN;
        if (smp_last) begin
          fcnt_nxt = frame_count + 1'b1;
          if (!enable) state_nxt = IDLE;
        end
      end
    end
  end

  // Push packing: terminator, then header, then sample, into at most two slots.
  always_comb begin
    n_push  = 2'd0;
    push_w0 = '0;
    push_w1 = '0;
    if (push_term) begin
      push_w0 = word_pack('0, 1'b1, 1'b1);
      n_push  = 2'd1;
    end
    if (push_hdr) begin
      if (n_push == 2'd0) push_w0 = word_pack(DATA_WIDTH'(seq), 1'b0, 1'b0);
      else                push_w1 = word_pack(DATA_WIDTH'(seq), 1'b0, 1'b0);
      n_push = n_push + 2'd1;
    end
    if (push_smp) begin
      if (n_push == 2'd0) push_w0 = word_pack(din, smp_last, 1'b0);
      else                push_w1 = word_pack(din, smp_last, 1'b0);
      n_push = n_push + 2'd1;
    end
  end

  // Buffer storage: data entries carry no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) buf_mem[wr_ptr]         <= push_w0;
    if (n_push == 2'd2) buf_mem[wr_ptr + 2'd1]  <= push_w1;
  end

  // Control state and buffer pointers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pos         <= '0;
      seq         <= '0;
      frame_count <= '0;
      pend        <= 1'b0;
      status_drop <= 1'b0;
      rd_ptr      <= 2'd0;
      wr_ptr      <= 2'd0;
      count       <= 3'd0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      seq         <= seq_nxt;
      frame_count <= fcnt_nxt;
      pend        <= pend_nxt;
      status_drop <= drop_nxt;
      rd_ptr      <= rd_ptr + {1'b0, pop};
      wr_ptr      <= wr_ptr + n_push;
      count       <= count + {1'b0, n_push} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer with FRAME_LEN=4: expected words are
// queued as stimulus is issued and a monitor compares every accepted word.
module tb_axis_frame_packer;

  localparam int DW = 32;
  localparam int SW = 16;

  logic          clk, rst_n;
  logic [DW-1:0] din;
  logic          din_valid, sync_in, enable;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tuser, status_drop;
  logic [SW-1:0] frame_count;
  logic          tready_cmd, tog, tog_en;
  wire           tready = tog_en ? tog : tready_cmd;

  logic [DW+1:0] sbq [$];
  int checks = 0;
  int errors = 0;
  int drops  = 0;

  axis_frame_packer #(.DATA_WIDTH(DW), .FRAME_LEN(4), .SEQ_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .sync_in(sync_in), .enable(enable),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .status_drop(status_drop), .frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tog = 1'b0;
    forever begin
      @(posedge clk);
      #1 tog = ~tog;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, 1 required completion");
    $fatal(1, "timeout");
  end

  // Monitor: compare every accepted stream word against the scoreboard.
  always @(negedge clk) begin
    logic [DW+1:0] exp_w;
    if (rst_n && tvalid && tready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL stream_word: got unexpected data=%h last=%b user=%b, required no word",
                 tdata, tlast, tuser);
      end else begin
        exp_w = sbq.pop_front();
        if ({tdata, tlast, tuser} !== exp_w) begin
          errors++;
          $display("FAIL stream_word: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   tdata, tlast, tuser, exp_w[DW+1:2], exp_w[1], exp_w[0]);
        end
      end
    end
    if (rst_n && status_drop) drops++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic ex(input logic [DW-1:0] d, input logic l, input logic u);
    sbq.push_back({d, l, u});
  endtask

  task automatic smp(input logic [DW-1:0] d, input logic s, input logic en);
    din       = d;
    din_valid = 1'b1;
    sync_in   = s;
    enable    = en;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, sbq.size(), 0);
    idle(3);
  endtask

  task automatic sparse_frame(input int base, input logic s, input logic last_en,
                              input int seqv);
    ex(seqv, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ex(base + i, (i == 3), 1'b0);
      smp(base + i, s && (i == 0), (i == 3) ? last_en : 1'b1);
      idle(1);
    end
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sync_in = 1'b0; enable = 1'b0;
    tready_cmd = 1'b1; tog_en = 1'b0;
    #12;
    chk("reset_tvalid", tvalid, 0);
    chk("reset_status_drop", status_drop, 0);
    chk("reset_frame_count", frame_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Back-to-back frames with one initial sync.
    ex(0, 0, 0); for (int i = 1; i <= 4; i++) ex(i, i == 4, 0);
    ex(1, 0, 0); for (int i = 5; i <= 8; i++) ex(i, i == 8, 0);
    for (int i = 1; i <= 8; i++) smp(i, i == 1, 1'b1);
    drain("t1_drain", 20);
    chk("t1_frame_count", frame_count, 2);
    chk("t1_drops", drops, 0);

    // Enable dropped mid-frame: frame completes, then nothing new starts.
    ex(2, 0, 0); for (int i = 9; i <= 12; i++) ex(i, i == 12, 0);
    smp(9, 1'b0, 1'b1);
    smp(10, 1'b0, 1'b0);
    smp(11, 1'b0, 1'b0);
    smp(12, 1'b0, 1'b0);
    smp(13, 1'b1, 1'b0);
    smp(14, 1'b0, 1'b1);
    drain("t4_drain", 20);
    chk("t4_frame_count", frame_count, 3);

    // Backpressure loss: terminator, discard until pos wraps, then new frame.
    tready_cmd = 1'b0;
    ex(3, 0, 0); ex(21, 0, 0); ex(22, 0, 0); ex(23, 0, 0); ex(0, 1, 1);
    smp(21, 1'b1, 1'b1);
    smp(22, 1'b0, 1'b1);
    smp(23, 1'b0, 1'b1);
    chk("t2_tvalid_held", tvalid, 1);
    smp(24, 1'b0, 1'b1);
    smp(25, 1'b0, 1'b1);
    smp(26, 1'b0, 1'b1);
    idle(1);
    chk("t2_drop_pulse", drops, 1);
    tready_cmd = 1'b1;
    drain("t2_drain_bad", 20);
    ex(4, 0, 0); for (int i = 29; i <= 32; i++) ex(i, i == 32, 0);
    for (int i = 27; i <= 32; i++) smp(i, 1'b0, 1'b1);
    drain("t2_drain_new", 20);
    chk("t2_frame_count", frame_count, 4);
    chk("t2_drops", drops, 1);

    // Mid-frame sync: terminator, then wait for the next sync.
    ex(5, 0, 0); ex(41, 0, 0); ex(42, 0, 0); ex(0, 1, 1);
    smp(41, 1'b1, 1'b1);
    smp(42, 1'b0, 1'b1);
    smp(43, 1'b1, 1'b1);
    smp(44, 1'b0, 1'b1);
    ex(6, 0, 0); for (int i = 45; i <= 48; i++) ex(i, i == 48, 0);
    smp(45, 1'b1, 1'b1);
    smp(46, 1'b0, 1'b1);
    smp(47, 1'b0, 1'b1);
    smp(48, 1'b0, 1'b0);
    drain("t3_drain", 20);
    chk("t3_frame_count", frame_count, 5);
    chk("t3_drops", drops, 2);

    // Toggling tready with sparse input: no loss, consecutive sequence numbers.
    enable = 1'b1;
    tog_en = 1'b1;
    sparse_frame(100, 1'b1, 1'b1, 7);
    sparse_frame(104, 1'b0, 1'b1, 8);
    sparse_frame(108, 1'b0, 1'b0, 9);
    drain("t6_drain", 40);
    tog_en = 1'b0;
    tready_cmd = 1'b1;
    chk("t6_frame_count", frame_count, 8);
    chk("t6_drops", drops, 2);

    // Asynchronous reset mid-frame: outputs clear without a clock edge.
    tready_cmd = 1'b0;
    smp(200, 1'b1, 1'b1);
    chk("t5_tvalid_before", tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tvalid_async", tvalid, 0);
    chk("t5_frame_count_async", frame_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tready_cmd = 1'b1;
    idle(2);
    ex(0, 0, 0); for (int i = 201; i <= 204; i++) ex(i, i == 204, 0);
    for (int i = 201; i <= 204; i++) smp(i, i == 201, 1'b1);
    drain("t5_drain", 20);
    chk("t5_frame_count", frame_count, 1);
    chk("final_drops", drops, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_packer.md
Name: axis_frame_packer

Overview:
- Converts the continuous, non-backpressured sample stream from the DSP/DoA pipeline into AXI4-Stream frames, and feeds the input side of the stream FIFO.
- Each frame is one header word carrying a sequence number, followed by FRAME_LEN payload samples. The last payload word has tlast=1.
- Lost samples, whether from downstream backpressure or a mid-frame sync, end the frame early with a terminator word carrying tuser=1. A downstream FIFO configured to drop bad frames discards these frames.

Parameters:
- DATA_WIDTH, 32, sample and stream word width in bits.
- FRAME_LEN, 256, payload samples per frame. Must be at least 2.
- SEQ_WIDTH, 16, width of the sequence field in the header and of frame_count. Must be at most DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  sample data.
- din_valid  in  1  sample strobe. There is no backpressure on this input.
- sync_in  in  1  qualifies the din_valid sample in the same cycle as payload position 0.
- enable  in  1  permits new frames to start.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  end of frame.
- m_axis_tuser  out  1  bad-frame flag. Meaningful only on the tlast word.
- status_drop  out  1  one-cycle pulse when a frame is marked bad.
- frame_count  out  SEQ_WIDTH  count of good frames completed. Wraps at its width.

Behaviour:
- Reset (asynchronous, active-low; clk and rst_n as decided):
  - Takes effect immediately: buffer empty, m_axis_tvalid=0, status_drop=0.
  - Internal state: state=IDLE, pos=0, seq=0, frame_count=0, terminator-pending flag cleared.
  - Reset mid-frame abandons the frame; no terminator is emitted.
- Buffer:
  - 4-entry register FIFO, each entry holding {data, last, user}.
  - Up to 2 pushes and 1 pop per cycle.
  - m_axis_* are driven from the head entry; m_axis_tvalid = buffer not empty.
  - A pop occurs on tvalid && tready.
  - Free space for the current cycle counts that cycle's pop.
- Words:
  - Header: data = zero-extended seq, last=0, user=0.
  - Payload: data = din, last=(pos==FRAME_LEN-1), user=0.
  - Terminator: data=0, last=1, user=1.
- Latency: with the buffer empty and tready=1, a frame-start sample in cycle N produces the header at N+1 and the sample at N+2. A mid-frame sample appears at N+1.
- Position counter pos counts every din_valid sample while in RUN or DISCARD, including lost ones. It wraps FRAME_LEN-1 -> 0.
- IDLE:
  - din_valid && sync_in && enable is a frame start, handled as in RUN at pos 0.
  - All other samples are ignored.
- RUN, on din_valid:
  - sync_in && pos!=0:
    - Sample discarded; pos=0; go to IDLE.
    - Terminator queued: pushed if space is available, otherwise set pending.
    - status_drop pulses.
  - Required pushes are 2 at pos==0 (header + sample) and 1 otherwise. If free space < required:
    - Sample lost; pos advances; go to DISCARD.
    - If pos!=0, terminator set pending and status_drop pulses.
    - If pos==0, nothing was pushed for this frame, so no terminator and no pulse.
  - Otherwise:
    - Push the header (at pos==0, then seq++) and the sample.
    - At pos==FRAME_LEN-1: frame_count++; if !enable go to IDLE.
- DISCARD:
  - On din_valid, pos advances and the sample is discarded.
  - A sample at pos==0 or with sync_in (sync_in forces pos=0) is a frame-start candidate.
  - If enable is high, the terminator is not pending and space is >=2, that sample starts a frame in RUN.
  - Otherwise remain in DISCARD.
- Pending terminator:
  - Pushed in the first cycle with free space >=1.
  - Takes priority over any new-frame push in the same cycle.
- Simultaneous push and pop in the same cycle is legal; occupancy never exceeds 4.
- Sustained 100% input duty leaves a net +1 word per frame, so an idle slot per frame is required to avoid loss.
- seq increments on every header emitted, including frames later marked bad. frame_count counts only frames completed with tuser=0.

Test Plan:
1. FRAME_LEN=4, tready=1, enable=1, sync with sample 1, samples 1..8 back-to-back -> output hdr(0),1,2,3,4(tlast,tuser=0),hdr(1),5,6,7,8(tlast); frame_count=2; status_drop never pulses.
2. FRAME_LEN=8, tready=0, frame start then samples 1..4 -> buffer holds hdr,1,2,3; sample 4 lost with status_drop pulse. tready=1 -> out hdr,1,2,3, then terminator (data 0, tlast=1, tuser=1). Further samples are discarded until pos wraps, then a new header with seq=1 appears; frame_count=0.
3. FRAME_LEN=8, sync_in asserted on the 3rd payload sample -> out hdr,s0,s1,terminator(tuser=1); status_drop pulse; next frame only after the next sync_in.
4. FRAME_LEN=4, enable dropped at payload position 1 -> frame completes with tlast,tuser=0; no further header; frame_count=1.
5. rst_n low mid-frame with tvalid=1 -> tvalid=0 without a clock edge. After release: IDLE, seq restarts at 0, and the next sync produces hdr(0).
6. FRAME_LEN=4, tready toggled 1/0 every cycle, samples every other cycle -> no loss; every frame intact, in order, with consecutive seq.
